// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types and constants for the ctrl_pipe control pipeline.
// Holds the default index/ALU-control widths, the forwarding-select encodings
// and the per-stage control bundles together with their bubble values.
package ctrl_pipe_pkg;

    // Default register-index and ALU-control widths
    localparam int RAW_DEFAULT = 5;
    localparam int ACW_DEFAULT = 6;

    // Operand source selects driven on fwd_a / fwd_b
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Control bits held in ID/EX
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic alu_src;
        logic branch;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    // Control bits held in EX/MEM
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    // Control bits held in MEM/WB
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // A bubble is an invalid slot with every control bit cleared
    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: combinational branch resolution, stall generation and, when
// CTRL_PIPE_FWD_EN is defined, operand forwarding selects for the EX stage.
// Without forwarding, any read of a register still being produced in EX or MEM
// stalls decode until the producer reaches WB.
module hazard_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int RAW = RAW_DEFAULT
) (
    input  logic           id_valid,
    input  logic           id_AluSrc,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           ex_valid,
`ifndef CTRL_PIPE_FWD_EN
    input  logic           ex_RegWrite,
`endif
    input  logic           ex_MemtoReg,
    input  logic           ex_Branch,
    input  logic           ex_zero,
    input  logic [RAW-1:0] ex_writereg,
    input  logic           mem_valid,
    input  logic           mem_RegWrite,
    input  logic [RAW-1:0] mem_writereg,
`ifdef CTRL_PIPE_FWD_EN
    input  logic [RAW-1:0] ex_rs,
    input  logic [RAW-1:0] ex_rt,
    input  logic           wb_valid,
    input  logic           wb_RegWrite,
    input  logic [RAW-1:0] wb_writereg,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b,
`endif
    output logic           pc_src,
    output logic           stall
);

    logic rt_used;
    logic load_use;

    // Branch taken when the instruction in EX is a valid branch with zero set
    always_comb begin
        pc_src = ex_valid & ex_Branch & ex_zero;
    end

    // Load in EX whose destination is read by the instruction in decode
    always_comb begin
        rt_used  = ~id_AluSrc;
        load_use = id_valid & ex_valid & ex_MemtoReg & (ex_writereg != '0) &
                   ((id_rs == ex_writereg) | (rt_used & (id_rt == ex_writereg)));
    end

`ifdef CTRL_PIPE_FWD_EN

    // Pick the youngest producer of each EX operand; EX/MEM beats MEM/WB
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (mem_valid & mem_RegWrite & (mem_writereg != '0) & (mem_writereg == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_valid & wb_RegWrite & (wb_writereg != '0) & (wb_writereg == ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (mem_valid & mem_RegWrite & (mem_writereg != '0) & (mem_writereg == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_valid & wb_RegWrite & (wb_writereg != '0) & (wb_writereg == ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    // With forwarding only a load-use pair must wait; a taken branch overrides it
    always_comb begin
        stall = load_use & ~pc_src;
    end

`else

    logic raw_ex;
    logic raw_mem;

    // Without forwarding, hold decode while EX or MEM still owes a source register
    always_comb begin
        raw_ex  = id_valid & ex_valid & ex_RegWrite & (ex_writereg != '0) &
                  ((id_rs == ex_writereg) | (rt_used & (id_rt == ex_writereg)));
        raw_mem = id_valid & mem_valid & mem_RegWrite & (mem_writereg != '0) &
                  ((id_rs == mem_writereg) | (rt_used & (id_rt == mem_writereg)));
        stall   = (load_use | raw_ex | raw_mem) & ~pc_src;
    end

`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control lines and destination indices through the
// ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS core. Bubbles are
// inserted on stalls and taken branches. Define CTRL_PIPE_FWD_EN to register
// rs/rt in ID/EX and expose the fwd_a/fwd_b forwarding selects.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int RAW = RAW_DEFAULT,
    parameter int ACW = ACW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic           id_RegWrite,
    input  logic           id_RegDst,
    input  logic           id_AluSrc,
    input  logic           id_Branch,
    input  logic           id_MemWrite,
    input  logic           id_MemtoReg,
    input  logic [ACW-1:0] id_AluControl,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           ex_zero,
    output logic           ex_valid,
    output logic           ex_AluSrc,
    output logic           ex_Branch,
    output logic [ACW-1:0] ex_AluControl,
    output logic [RAW-1:0] ex_writereg,
    output logic           mem_valid,
    output logic           mem_RegWrite,
    output logic           mem_MemWrite,
    output logic           mem_MemtoReg,
    output logic [RAW-1:0] mem_writereg,
    output logic           wb_valid,
    output logic           wb_RegWrite,
    output logic           wb_MemtoReg,
    output logic [RAW-1:0] wb_writereg,
`ifdef CTRL_PIPE_FWD_EN
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b,
`endif
    output logic           pc_src,
    output logic           stall,
    output logic           flush_ifid
);

    ex_ctrl_t       ex_ctrl_q,      ex_ctrl_d;
    logic [ACW-1:0] ex_alu_ctl_q,   ex_alu_ctl_d;
    logic [RAW-1:0] ex_writereg_q,  ex_writereg_d;
`ifdef CTRL_PIPE_FWD_EN
    logic [RAW-1:0] ex_rs_q,        ex_rs_d;
    logic [RAW-1:0] ex_rt_q,        ex_rt_d;
`endif
    mem_ctrl_t      mem_ctrl_q,     mem_ctrl_d;
    logic [RAW-1:0] mem_writereg_q, mem_writereg_d;
    wb_ctrl_t       wb_ctrl_q,      wb_ctrl_d;
    logic [RAW-1:0] wb_writereg_q,  wb_writereg_d;

    logic [RAW-1:0] id_writereg;
    logic           capture;

    // ID/EX takes the decoded instruction unless it is invalid, stalled or squashed
    always_comb begin
        id_writereg   = id_RegDst ? id_rd : id_rt;
        capture       = id_valid & ~stall & ~pc_src;
        ex_ctrl_d     = EX_BUBBLE;
        ex_alu_ctl_d  = '0;
        ex_writereg_d = '0;
`ifdef CTRL_PIPE_FWD_EN
        ex_rs_d       = '0;
        ex_rt_d       = '0;
`endif
        if (capture) begin
            ex_ctrl_d.valid      = 1'b1;
            ex_ctrl_d.reg_write  = id_RegWrite & (id_writereg != '0);
            ex_ctrl_d.alu_src    = id_AluSrc;
            ex_ctrl_d.branch     = id_Branch;
            ex_ctrl_d.mem_write  = id_MemWrite;
            ex_ctrl_d.mem_to_reg = id_MemtoReg;
            ex_alu_ctl_d         = id_AluControl;
            ex_writereg_d        = id_writereg;
`ifdef CTRL_PIPE_FWD_EN
            ex_rs_d              = id_rs;
            ex_rt_d              = id_rt;
`endif
        end
    end

    // EX/MEM and MEM/WB simply advance every cycle
    always_comb begin
        mem_ctrl_d.valid      = ex_ctrl_q.valid;
        mem_ctrl_d.reg_write  = ex_ctrl_q.reg_write;
        mem_ctrl_d.mem_write  = ex_ctrl_q.mem_write;
        mem_ctrl_d.mem_to_reg = ex_ctrl_q.mem_to_reg;
        mem_writereg_d        = ex_writereg_q;
        wb_ctrl_d.valid       = mem_ctrl_q.valid;
        wb_ctrl_d.reg_write   = mem_ctrl_q.reg_write;
        wb_ctrl_d.mem_to_reg  = mem_ctrl_q.mem_to_reg;
        wb_writereg_d         = mem_writereg_q;
    end

    // Pipeline registers; reset empties every stage at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q      <= EX_BUBBLE;
            ex_alu_ctl_q   <= '0;
            ex_writereg_q  <= '0;
`ifdef CTRL_PIPE_FWD_EN
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
`endif
            mem_ctrl_q     <= MEM_BUBBLE;
            mem_writereg_q <= '0;
            wb_ctrl_q      <= WB_BUBBLE;
            wb_writereg_q  <= '0;
        end else begin
            ex_ctrl_q      <= ex_ctrl_d;
            ex_alu_ctl_q   <= ex_alu_ctl_d;
            ex_writereg_q  <= ex_writereg_d;
`ifdef CTRL_PIPE_FWD_EN
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
`endif
            mem_ctrl_q     <= mem_ctrl_d;
            mem_writereg_q <= mem_writereg_d;
            wb_ctrl_q      <= wb_ctrl_d;
            wb_writereg_q  <= wb_writereg_d;
        end
    end

    hazard_unit #(
        .RAW(RAW)
    ) u_hazard (
        .id_valid     (id_valid),
        .id_AluSrc    (id_AluSrc),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_valid     (ex_ctrl_q.valid),
`ifndef CTRL_PIPE_FWD_EN
        .ex_RegWrite  (ex_ctrl_q.reg_write),
`endif
        .ex_MemtoReg  (ex_ctrl_q.mem_to_reg),
        .ex_Branch    (ex_ctrl_q.branch),
        .ex_zero      (ex_zero),
        .ex_writereg  (ex_writereg_q),
        .mem_valid    (mem_ctrl_q.valid),
        .mem_RegWrite (mem_ctrl_q.reg_write),
        .mem_writereg (mem_writereg_q),
`ifdef CTRL_PIPE_FWD_EN
        .ex_rs        (ex_rs_q),
        .ex_rt        (ex_rt_q),
        .wb_valid     (wb_ctrl_q.valid),
        .wb_RegWrite  (wb_ctrl_q.reg_write),
        .wb_writereg  (wb_writereg_q),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
`endif
        .pc_src       (pc_src),
        .stall        (stall)
    );

    assign flush_ifid    = pc_src;

    assign ex_valid      = ex_ctrl_q.valid;
    assign ex_AluSrc     = ex_ctrl_q.alu_src;
    assign ex_Branch     = ex_ctrl_q.branch;
    assign ex_AluControl = ex_alu_ctl_q;
    assign ex_writereg   = ex_writereg_q;

    assign mem_valid     = mem_ctrl_q.valid;
    assign mem_RegWrite  = mem_ctrl_q.reg_write;
    assign mem_MemWrite  = mem_ctrl_q.mem_write;
    assign mem_MemtoReg  = mem_ctrl_q.mem_to_reg;
    assign mem_writereg  = mem_writereg_q;

    assign wb_valid      = wb_ctrl_q.valid;
    assign wb_RegWrite   = wb_ctrl_q.reg_write;
    assign wb_MemtoReg   = wb_ctrl_q.mem_to_reg;
    assign wb_writereg   = wb_writereg_q;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the decoder's control bundle.
- Carries decoded control lines (RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, AluControl) and register indices from decode through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves branches in EX (pc_src = Branch AND zero) and detects load-use hazards, inserting bubbles and requesting upstream stalls/flushes.
- Sits between the control unit and the datapath of the 5-stage MIPS core.

Parameters:
- RAW, default 5: register-index width.
- ACW, default 6: AluControl width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_RegWrite, id_RegDst, id_AluSrc, id_Branch, id_MemWrite, id_MemtoReg  in  1 each  decoded controls.
- id_AluControl  in  ACW  decoded ALU operation.
- id_rs, id_rt, id_rd  in  RAW each  instruction register fields.
- ex_zero  in  1  ALU zero flag for the instruction in EX.
- ex_valid, ex_AluSrc, ex_Branch  out  1 each.
- ex_AluControl  out  ACW.
- ex_writereg  out  RAW  destination: rd if RegDst else rt, selected when captured.
- mem_valid, mem_RegWrite, mem_MemWrite, mem_MemtoReg  out  1 each.
- mem_writereg  out  RAW.
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each.
- wb_writereg  out  RAW.
- pc_src  out  1  branch taken in EX (combinational).
- stall  out  1  hold PC and IF/ID (combinational).
- flush_ifid  out  1  squash IF/ID (equals pc_src).

Behaviour:
- Clocking: one clock domain (clk); reset rst_n is asynchronous, active-low.
- Reset: all registered outputs 0 (valid bits, control bits, AluControl, writereg indices). pc_src/stall/flush_ifid therefore evaluate to 0.
- Bubble definition: valid=0 and every control bit 0, AluControl 0, writereg 0.
- Per-cycle advance (no global hold): EX/MEM <= ID/EX and MEM/WB <= EX/MEM every clock.
- ID/EX capture:
  - Takes id_* when id_valid=1, stall=0 and pc_src=0.
  - Otherwise takes a bubble.
- Latency: decode to EX outputs 1 cycle; to MEM 2 cycles; to WB 3 cycles.
- Gating: a stage's control outputs are 0 whenever its valid is 0.
- Register zero: RegWrite is cleared when the captured writereg is 0, so stores to $0 never reach WB.
- pc_src = ex_valid & ex_Branch & ex_zero.
- stall (load-use) = ex_valid & ex_MemtoReg & ex_writereg!=0 & (id_rs==ex_writereg | (id_rt==ex_writereg & !id_AluSrc)), qualified with id_valid.
- Simultaneous pc_src and stall: pc_src wins. stall is forced to 0, ID/EX gets a bubble, and flush_ifid=1.
- Stall duration: stall lasts exactly one cycle per load-use pair, because the bubble leaves EX next cycle.
- Back-to-back branches: the second branch never reaches EX if the first is taken (squashed).
- Reset asserted mid-operation: all stages become bubbles immediately. In-flight stores and writebacks are dropped.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- Defined:
  - ID/EX additionally registers rs/rt.
  - Adds outputs fwd_a and fwd_b (2 bits each): 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
  - Select rule: EX/MEM wins when mem_RegWrite & mem_writereg!=0 & match; else MEM/WB on the same rule. The match is against ID/EX's registered rs (for fwd_a) or rt (for fwd_b).
  - stall covers load-use only.
- Undefined:
  - No forwarding ports.
  - stall also asserts when id_rs or id_rt (rt only if !id_AluSrc) matches a nonzero writereg of a valid RegWrite instruction in EX or MEM.
  - This RAW stall repeats each cycle until the hazard clears.

Decomposition:
- Shared header ctrl_pipe_defs.vh holds:
  - Bubble constant.
  - FWD_REG / FWD_MEM / FWD_WB encodings.
  - Default RAW/ACW.
- Natural sub-module: hazard_unit (combinational stall, pc_src and fwd selects). ctrl_pipe keeps the three register stages.

Test Plan:
- Reset: hold rst_n=0 with random id_*, then release -> all outputs 0. A valid R-type add (rd=3) gives ex_valid=1 one cycle later, mem 2 cycles, wb_RegWrite=1 with wb_writereg=3 at 3 cycles.
- Load-use: lw rt=5 then add rs=5 -> stall=1 for exactly one cycle, bubble in EX. The add reaches EX one cycle later; wb sequence is lw, bubble, add.
- Branch taken: beq with ex_zero=1 -> pc_src=1 and flush_ifid=1 for one cycle. The next ID instruction becomes a bubble (ex_valid=0 next cycle). With ex_zero=0, no flush.
- Priority: branch taken in EX while a load-use match exists in ID -> stall=0, pc_src=1, ID/EX bubble.
- Register $0: add rd=0 -> wb_RegWrite=0 and wb_valid=1. A lw rt=0 followed by a user of $0 causes no stall.
- FWD build: add rd=4; add rs=4 -> fwd_a=10 in EX. With one instruction between -> fwd_a=01. Non-FWD build: same sequence stalls 2 cycles, then 1 cycle.
